// File: rtl/svc_axi_bram.sv
// AXI4 responder over an on-chip word array; optional range check via SVC_AXI_BRAM_BOUNDS_EN.
// Latency: B one cycle after the wlast beat; first R beat one cycle after AR, then 1 beat/cycle.
// Backpressure: R outputs and B hold while rready/bready low; AW/AR accepted only when idle.
module svc_axi_bram #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int MEM_DEPTH_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,

    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,

    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,

    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,

    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast
);

    localparam int STRB  = AXI_DATA_WIDTH / 8;
    localparam int LSB   = $clog2(STRB);
    localparam int DEPTH = 1 << MEM_DEPTH_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [MEM_DEPTH_WIDTH-1:0] idx_t;
    localparam idx_t IDX_ONE = {{(MEM_DEPTH_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic aw_oor, ar_oor;
    logic wr_oor, rd_oor;
    idx_t aw_idx, ar_idx;
    idx_t wr_idx, rd_idx;
    logic [7:0] rd_rem;

    assign aw_idx = s_axi_awaddr[LSB +: MEM_DEPTH_WIDTH];
    assign ar_idx = s_axi_araddr[LSB +: MEM_DEPTH_WIDTH];

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

`ifdef SVC_AXI_BRAM_BOUNDS_EN
    // Any set bit above the stored index range marks the whole burst out of range.
    localparam logic [AXI_ADDR_WIDTH-1:0] HI_MASK =
        {AXI_ADDR_WIDTH{1'b1}} << (LSB + MEM_DEPTH_WIDTH);
    assign aw_oor = |(s_axi_awaddr & HI_MASK);
    assign ar_oor = |(s_axi_araddr & HI_MASK);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Burst type, size and length are not needed: every burst is INCR, full width.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awlen, s_axi_awsize, s_axi_awburst,
                         s_axi_arsize, s_axi_arburst, s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx      <= '0;
            wr_oor      <= 1'b0;
            s_axi_bid   <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else if (aw_hs) begin
            wr_idx      <= aw_idx;
            wr_oor      <= aw_oor;
            s_axi_bid   <= s_axi_awid;
            s_axi_bresp <= aw_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (w_hs) begin
            wr_idx      <= wr_idx + IDX_ONE;
        end
    end

    // Storage is deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_hs && !wr_oor) begin
            for (int b = 0; b < STRB; b++) begin
                if (s_axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Reads sample mem on the same edge a write lands, so a collision returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx      <= '0;
            rd_rem      <= '0;
            rd_oor      <= 1'b0;
            s_axi_rdata <= '0;
            s_axi_rid   <= '0;
            s_axi_rresp <= RESP_OKAY;
            s_axi_rlast <= 1'b0;
        end else if (ar_hs) begin
            rd_idx      <= ar_idx + IDX_ONE;
            rd_rem      <= s_axi_arlen;
            rd_oor      <= ar_oor;
            s_axi_rdata <= ar_oor ? '0 : mem[ar_idx];
            s_axi_rid   <= s_axi_arid;
            s_axi_rresp <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            s_axi_rlast <= (s_axi_arlen == 8'd0);
        end else if (r_hs) begin
            if (s_axi_rlast) begin
                s_axi_rlast <= 1'b0;
            end else begin
                rd_idx      <= rd_idx + IDX_ONE;
                rd_rem      <= rd_rem - 8'd1;
                s_axi_rdata <= rd_oor ? '0 : mem[rd_idx];
                s_axi_rlast <= (rd_rem == 8'd1);
            end
        end
    end

endmodule

// File: tb/tb_svc_axi_bram.sv
// Directed bench for svc_axi_bram (16-word array) with R/B expectation queues checked by a monitor.
module tb_svc_axi_bram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  awid, bid, arid, rid;
    logic [19:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp, wstrb;
    logic [15:0] wdata, rdata;

    always #5 clk = ~clk;

    svc_axi_bram #(
        .AXI_ADDR_WIDTH(20), .AXI_DATA_WIDTH(16), .AXI_ID_WIDTH(4), .MEM_DEPTH_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] data;
        logic        last;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [15:0] model [16];
    logic [15:0] wbuf  [16];
    logic [1:0]  sbuf  [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares accepted beats against the queues and checks R stability under stall.
    initial begin
        rexp_t       e;
        bexp_t       be;
        logic        stalled;
        logic [15:0] s_data;
        logic [3:0]  s_id;
        logic [1:0]  s_resp;
        logic        s_last;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("r_hold_valid", 32'(rvalid), 32'd1);
                    check("r_hold_data",  32'(rdata),  32'(s_data));
                    check("r_hold_last",  32'(rlast),  32'(s_last));
                    check("r_hold_id",    32'(rid),    32'(s_id));
                    check("r_hold_resp",  32'(rresp),  32'(s_resp));
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        check("r_unexpected_beat", 32'(rvalid), 32'd0);
                    end else begin
                        e = rq.pop_front();
                        check("r_data", 32'(rdata), 32'(e.data));
                        check("r_last", 32'(rlast), 32'(e.last));
                        check("r_id",   32'(rid),   32'(e.id));
                        check("r_resp", 32'(rresp), 32'(e.resp));
                    end
                end
                stalled = rvalid && !rready;
                s_data = rdata; s_id = rid; s_resp = rresp; s_last = rlast;
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        check("b_unexpected", 32'(bvalid), 32'd0);
                    end else begin
                        be = bq.pop_front();
                        check("b_id",   32'(bid),   32'(be.id));
                        check("b_resp", 32'(bresp), 32'(be.resp));
                    end
                end
            end
        end
    end

    task automatic write_burst(input logic [3:0] id, input logic [19:0] addr,
                               input int len, input logic [1:0] resp);
        int         cnt;
        logic [3:0] idx;
        bexp_t      be;
        be.id = id; be.resp = resp;
        bq.push_back(be);
        if (resp == 2'b00) begin
            for (int i = 0; i <= len; i++) begin
                idx = addr[4:1] + 4'(i);
                for (int b = 0; b < 2; b++)
                    if (sbuf[i][b]) model[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
        end
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len);
        cnt = 0;
        while (!awready && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check("aw_timeout", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len);
            cnt = 0;
            while (!wready && cnt < 100) begin @(posedge clk); #1; cnt++; end
            check("w_timeout", 32'(wready), 32'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        cnt = 0;
        while (bq.size() != 0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check("b_timeout", 32'(bq.size()), 32'd0);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [19:0] addr,
                              input int len, input logic [1:0] resp, input bit toggle);
        int    cnt;
        rexp_t e;
        for (int j = 0; j <= len; j++) begin
            e.id   = id;
            e.data = (resp != 2'b00) ? 16'h0000 : model[addr[4:1] + 4'(j)];
            e.last = (j == len);
            e.resp = resp;
            rq.push_back(e);
        end
        check("r_idle_before_ar", 32'(rvalid), 32'd0);
        arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len);
        cnt = 0;
        while (!arready && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check("ar_timeout", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("r_first_latency", 32'(rvalid), 32'd1);
        check("ar_busy", 32'(arready), 32'd0);
        cnt = 0;
        while (rq.size() != 0 && cnt < 300) begin
            @(posedge clk); #1; cnt++;
            if (toggle) rready = ~rready;
        end
        rready = 1'b1;
        check("r_timeout", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cnt;
        rexp_t e;
        rst_n = 1'b0;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd1; awburst = 2'b01;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd1; arburst = 2'b01;
        rready = 1'b1;
        #12;
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast",  32'(rlast),  32'd0);
        check("rst_rdata",  32'(rdata),  32'd0);
        check("rst_bid",    32'(bid),    32'd0);
        check("rst_rid",    32'(rid),    32'd0);
        check("rst_bresp",  32'(bresp),  32'd0);
        check("rst_rresp",  32'(rresp),  32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("awready_after_rst", 32'(awready), 32'd1);
        check("arready_after_rst", 32'(arready), 32'd1);

        // Single beat write then read.
        wbuf[0] = 16'hBEEF; sbuf[0] = 2'b11;
        write_burst(4'd3, 20'h00010, 0, 2'b00);
        read_burst(4'd3, 20'h00010, 0, 2'b00, 1'b0);

        // Burst, then partial-strobe rewrite of beat 2.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 16'(i + 1); sbuf[i] = 2'b11; end
        write_burst(4'd1, 20'h00000, 3, 2'b00);
        wbuf[0] = 16'hAA55; sbuf[0] = 2'b01;
        write_burst(4'd2, 20'h00004, 0, 2'b00);
        read_burst(4'd5, 20'h00000, 3, 2'b00, 1'b0);

        // Eight-beat read with rready toggling every cycle.
        for (int i = 0; i < 8; i++) begin wbuf[i] = 16'h1000 + 16'(i) * 16'h0111; sbuf[i] = 2'b11; end
        write_burst(4'd4, 20'h00000, 7, 2'b00);
        read_burst(4'd9, 20'h00000, 7, 2'b00, 1'b1);

        // Index wrap 14,15,0,1.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 16'hA0A0 + 16'(i) * 16'h0101; sbuf[i] = 2'b11; end
        write_burst(4'd10, 20'h0001C, 3, 2'b00);
        read_burst(4'd11, 20'h00000, 0, 2'b00, 1'b0);
        read_burst(4'd12, 20'h0001C, 3, 2'b00, 1'b0);

        // Overlapping write and read of words 4..7: every read beat collides with its write.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 16'hC000 + 16'(i); sbuf[i] = 2'b11; end
        for (int j = 0; j < 4; j++) begin
            e.id = 4'd8; e.data = model[4 + j]; e.last = (j == 3); e.resp = 2'b00;
            rq.push_back(e);
        end
        for (int j = 0; j < 4; j++) model[4 + j] = wbuf[j];
        bq.push_back(bexp_t'{id: 4'd7, resp: 2'b00});
        awvalid = 1'b1; awid = 4'd7; awaddr = 20'h00008; awlen = 8'd3;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("aw_busy", 32'(awready), 32'd0);
        arvalid = 1'b1; arid = 4'd8; araddr = 20'h00008; arlen = 8'd3;
        wvalid = 1'b1; wdata = wbuf[0]; wstrb = 2'b11; wlast = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wdata = wbuf[i]; wlast = (i == 3);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        cnt = 0;
        while ((rq.size() != 0 || bq.size() != 0) && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check("concurrent_timeout", 32'(rq.size() + bq.size()), 32'd0);
        read_burst(4'd13, 20'h00008, 3, 2'b00, 1'b0);

        // Reset while beat 2 of an eight-beat read is on the bus.
        for (int j = 0; j < 8; j++) begin
            e.id = 4'd6; e.data = model[j]; e.last = (j == 7); e.resp = 2'b00;
            rq.push_back(e);
        end
        arvalid = 1'b1; arid = 4'd6; araddr = 20'h00000; arlen = 8'd7;
        @(posedge clk); #1;
        arvalid = 1'b0;
        cnt = 0;
        while (rq.size() > 5 && cnt < 50) begin @(negedge clk); #1; cnt++; end
        check("rst_mid_beats_seen", 32'(rq.size()), 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rlast",  32'(rlast),  32'd0);
        check("rst_mid_rdata",  32'(rdata),  32'd0);
        check("rst_mid_rid",    32'(rid),    32'd0);
        rq.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_arready", 32'(arready), 32'd1);
        check("rst_mid_awready", 32'(awready), 32'd1);
        read_burst(4'd14, 20'h00010, 0, 2'b00, 1'b0);

`ifdef SVC_AXI_BRAM_BOUNDS_EN
        wbuf[0] = 16'hDEAD; sbuf[0] = 2'b11;
        write_burst(4'd2, 20'h00020, 0, 2'b10);
        read_burst(4'd3, 20'h00020, 1, 2'b10, 1'b0);
        read_burst(4'd4, 20'h00000, 0, 2'b00, 1'b0);
`else
        // Upper address bits alias onto the stored range.
        read_burst(4'd15, 20'h40010, 0, 2'b00, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
